// File: rtl/spi_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_host_ctrl_if
// Brief   : Device-bus request/response bundle used by spi_host_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_host_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/spi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : spi_host_ctrl
// Brief   : Bus front end for spi_host: TX byte FIFO, STATUS register and the
//           start/busy handshake sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module spi_host_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    spi_host_ctrl_if.slave        bus,
    output logic                  spi_start_o,
    output logic [7:0]            spi_byte_o,
    input  logic                  spi_busy_i
);

    localparam int unsigned       c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_active;
    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_rdata_next;
    logic                 w_unused;

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_active = (r_state != ST_IDLE);

    // Full is judged on the pre-pop count, so a push racing a pop at full is dropped
    assign w_push = bus.req && bus.we && (bus.addr[3:2] == 2'd0) && bus.be[0] && !w_full;

    assign w_rdata_next = (!bus.we && bus.addr[3:2] == 2'd1)
                        ? {29'd0, w_active, w_empty, w_full} : 32'd0;

    assign w_unused = ^{bus.addr[31:4], bus.addr[1:0], bus.be[3:1], bus.wdata[31:8]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.req;
            if (bus.req) r_rdata <= w_rdata_next;
        end
    end

    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        spi_start_o  = 1'b0;
        spi_byte_o   = '0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !spi_busy_i) w_state_next = ST_START;
            end
            ST_START: begin
                spi_start_o  = 1'b1;
                spi_byte_o   = r_mem[r_rd_ptr];
                w_pop        = !w_empty;
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy_i) w_state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!spi_busy_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_host_ctrl
// Brief   : Self-checking bench for spi_host_ctrl with a transfer-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_host_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_start;
    logic [7:0] spi_byte;
    logic       spi_busy = 1'b0;

    spi_host_ctrl_if bus();

    spi_host_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus.slave),
        .spi_start_o (spi_start),
        .spi_byte_o  (spi_byte),
        .spi_busy_i  (spi_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: queued bytes plus previous-cycle facts a new start depends on
    logic [7:0]  q[$];
    int          cyc = 0;
    int          p_size = 0;
    bit          p_active = 0;
    bit          p_busy = 0;
    bit          p_req = 0;
    bit          p_rd = 0;
    logic [31:0] p_rdata = '0;
    int          active_until = -1;
    int          busy_from = 1;
    int          busy_to = 0;
    int          xfer_len = 8;
    bit          ext_busy = 0;
    bit          rand_mode = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    // One bus cycle; entered and left just after a rising edge
    task automatic step(input bit rq, input bit wr, input logic [31:0] ad,
                        input logic [3:0] bem, input logic [31:0] wd);
        bit   exp_start;
        bit   cur_active;
        bit   cur_busy;
        int   sz;
        int   dly;
        logic [7:0] exp_byte;

        exp_start = !p_active && (p_size > 0) && !p_busy;
        exp_byte  = (exp_start && q.size() > 0) ? q[0] : 8'h00;
        check("spi_start", {31'd0, spi_start}, {31'd0, exp_start});
        check("spi_byte", {24'd0, spi_byte}, {24'd0, exp_byte});
        check("rvalid", {31'd0, bus.rvalid}, {31'd0, p_req});
        if (p_req && p_rd) check("rdata", bus.rdata, p_rdata);

        if (exp_start) begin
            if (rand_mode) xfer_len = $urandom_range(1, 5);
            dly          = rand_mode ? $urandom_range(0, 2) : 0;
            busy_from    = cyc + 1 + dly;
            busy_to      = busy_from + xfer_len - 1;
            active_until = busy_to + 1;
        end
        cur_active = exp_start || (cyc <= active_until);
        if (rand_mode) begin
            if (ext_busy && $urandom_range(0, 3) == 0) ext_busy = 0;
            else if (!ext_busy && !cur_active && $urandom_range(0, 15) == 0) ext_busy = 1;
        end
        cur_busy = ext_busy || (cyc >= busy_from && cyc <= busy_to);

        spi_busy  = cur_busy;
        bus.req   = rq;
        bus.we    = wr;
        bus.addr  = ad;
        bus.be    = bem;
        bus.wdata = wd;

        sz      = q.size();
        p_req   = rq;
        p_rd    = !wr;
        p_rdata = (ad[3:2] == 2'd1)
                ? {29'd0, cur_active, (sz == 0), (sz == DEPTH)} : 32'd0;
        if (exp_start && q.size() > 0) void'(q.pop_front());
        if (rq && wr && ad[3:2] == 2'd0 && bem[0] && sz < DEPTH) q.push_back(wd[7:0]);
        p_active = cur_active;
        p_busy   = cur_busy;
        p_size   = sz;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic wr_tx(input logic [7:0] b);
        step(1, 1, 32'h0, 4'hF, {24'hDEAD_00, b});
    endtask

    task automatic rd_status();
        step(1, 0, 32'h4, 4'hF, 32'h0);
    endtask

    function automatic bit start_next();
        return !p_active && (p_size > 0) && !p_busy;
    endfunction

    initial begin
        bus.req = 0; bus.we = 0; bus.addr = '0; bus.be = '0; bus.wdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", {31'd0, spi_start}, 32'd0);
        check("rst_byte", {24'd0, spi_byte}, 32'd0);
        check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;
        rd_status();
        idle(2);

        // Single byte, 8-cycle busy
        xfer_len = 8;
        wr_tx(8'hA5);
        idle(3);
        rd_status();
        idle(10);
        rd_status();
        idle(2);

        // Fill with busy held: full, ninth dropped, in-order drain
        ext_busy = 1;
        for (int i = 1; i <= 9; i++) wr_tx(8'(i));
        rd_status();
        idle(1);
        ext_busy = 0;
        xfer_len = 2;
        idle(60);
        rd_status();
        idle(2);

        // Ignored writes
        step(1, 1, 32'h0, 4'b1110, 32'h0000_0077);
        step(1, 1, 32'h8, 4'hF, 32'h0000_0066);
        rd_status();
        idle(4);

        // Reset while waiting for busy to drop
        xfer_len = 8;
        wr_tx(8'h11); wr_tx(8'h22); wr_tx(8'h33);
        idle(2);
        rd_status();
        rst_n    = 1'b0;
        spi_busy = 1'b0;
        bus.req  = 1'b0;
        #1;
        check("arst_start", {31'd0, spi_start}, 32'd0);
        check("arst_byte", {24'd0, spi_byte}, 32'd0);
        check("arst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("arst_rdata", bus.rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        p_size = 0; p_active = 0; p_busy = 0; p_req = 0; p_rd = 0;
        active_until = -1; busy_from = 1; busy_to = 0; ext_busy = 0;
        rd_status();
        idle(8);

        // Push while full on the same cycle as a pop
        xfer_len = 4;
        ext_busy = 1;
        for (int i = 0; i < DEPTH; i++) wr_tx(8'(8'h80 + i));
        ext_busy = 0;
        for (int k = 0; k < 10 && !start_next(); k++) idle(1);
        check("race_sync", {31'd0, start_next()}, 32'd1);
        wr_tx(8'hEE);
        rd_status();
        idle(80);
        rd_status();
        idle(2);

        // Randomised traffic
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ad;
            logic [3:0]  bem;
            ad       = $urandom;
            ad[3:2]  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bem      = 4'($urandom);
            if ($urandom_range(0, 4) != 0) bem[0] = 1'b1;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, ad, bem, $urandom);
        end
        rand_mode = 0;
        ext_busy  = 0;
        idle(120);
        rd_status();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
